// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the DataMemory word port of the load/store unit.
// The master side is the environment: the requester and DataMemory together.
interface load_store_unit_if #(
   parameter int ADDR_BITS = 7
);
   logic                 ReqValid;
   logic                 ReqReady;
   logic                 ReqWrite;
   logic [1:0]           ReqSize;
   logic                 ReqSigned;
   logic [31:0]          ReqAddr;
   logic [31:0]          ReqWData;
   logic                 RspValid;
   logic [31:0]          RspData;
   logic                 RspError;
   logic [ADDR_BITS-1:0] Address;
   logic [31:0]          WriteData;
   logic                 MemRead;
   logic                 MemWrite;
   logic [31:0]          ReadData;

   modport master (
      output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
      input  ReqReady, RspValid, RspData, RspError, Address, WriteData, MemRead, MemWrite
   );

   modport slave (
      input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, ReadData,
      output ReqReady, RspValid, RspData, RspError, Address, WriteData, MemRead, MemWrite
   );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store front end for a word-only DataMemory.
// Sub-word stores do read-modify-write; every output comes straight from a flop.
//
// state | meaning
// IDLE  | ReqReady high, waiting for a request
// RD0   | MemRead, first read cycle
// RD1   | MemRead, ReadData captured at the end of this cycle
// WR    | MemWrite for exactly one cycle
// RSP   | RspValid pulse, then back to IDLE
module load_store_unit #(
   parameter int ADDR_BITS = 7
) (
   input logic             Clk,
   input logic             Reset,
   load_store_unit_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RD0, RD1, WR, RSP} state_t;

   state_t               state_q, state_d;
   logic                 ready_q, ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [31:0]          rsp_data_q, rsp_data_d;
   logic                 rsp_error_q, rsp_error_d;
   logic [ADDR_BITS-1:0] address_q, address_d;
   logic [31:0]          write_data_q, write_data_d;
   logic                 mem_read_q, mem_read_d;
   logic                 mem_write_q, mem_write_d;
   logic                 write_q, write_d;
   logic [1:0]           size_q, size_d;
   logic                 signed_q, signed_d;
   logic [1:0]           lane_q, lane_d;
   logic [15:0]          wdata_q, wdata_d;
   logic                 req_err;

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
      logic [31:0] m;
      m = word;
      if (sz == 2'b00) m[{lane, 3'b000} +: 8] = wd[7:0];
      else             m[{lane[1], 4'b0000} +: 16] = wd[15:0];
      return m;
   endfunction

   // Alignment is already guaranteed, so the byte shift also serves halfwords.
   function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] sz,
                                                input logic sgn, input logic [1:0] lane);
      logic [15:0] sh;
      sh = 16'(word >> {lane, 3'b000});
      case (sz)
         2'b00:   return {{24{sgn & sh[7]}}, sh[7:0]};
         2'b01:   return {{16{sgn & sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

   assign req_err = (bus.ReqSize == 2'b11)
                 || (bus.ReqSize == 2'b01 && bus.ReqAddr[0])
                 || (bus.ReqSize == 2'b10 && bus.ReqAddr[1:0] != 2'b00)
                 || ((bus.ReqAddr >> (ADDR_BITS + 2)) != 32'd0);

   always_comb begin
      state_d      = state_q;
      rsp_valid_d  = 1'b0;
      rsp_data_d   = 32'd0;
      rsp_error_d  = 1'b0;
      write_data_d = 32'd0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      address_d    = address_q;
      write_d      = write_q;
      size_d       = size_q;
      signed_d     = signed_q;
      lane_d       = lane_q;
      wdata_d      = wdata_q;
      case (state_q)
         IDLE: begin
            if (bus.ReqValid) begin
               write_d   = bus.ReqWrite;
               size_d    = bus.ReqSize;
               signed_d  = bus.ReqSigned;
               lane_d    = bus.ReqAddr[1:0];
               wdata_d   = bus.ReqWData[15:0];
               address_d = bus.ReqAddr[ADDR_BITS+1:2];
               if (req_err) begin
                  state_d     = RSP;
                  rsp_valid_d = 1'b1;
                  rsp_error_d = 1'b1;
               end else if (bus.ReqWrite && bus.ReqSize == 2'b10) begin
                  state_d      = WR;
                  mem_write_d  = 1'b1;
                  write_data_d = bus.ReqWData;
               end else begin
                  state_d    = RD0;
                  mem_read_d = 1'b1;
               end
            end
         end
         RD0: begin
            state_d    = RD1;
            mem_read_d = 1'b1;
         end
         RD1: begin
            if (write_q) begin
               state_d      = WR;
               mem_write_d  = 1'b1;
               write_data_d = merge_lane(bus.ReadData, wdata_q, size_q, lane_q);
            end else begin
               state_d     = RSP;
               rsp_valid_d = 1'b1;
               rsp_data_d  = extract_lane(bus.ReadData, size_q, signed_q, lane_q);
            end
         end
         WR: begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
         end
         RSP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= IDLE;
         ready_q      <= 1'b1;
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= 32'd0;
         rsp_error_q  <= 1'b0;
         address_q    <= '0;
         write_data_q <= 32'd0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         write_q      <= 1'b0;
         size_q       <= 2'b00;
         signed_q     <= 1'b0;
         lane_q       <= 2'b00;
         wdata_q      <= 16'd0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_error_q  <= rsp_error_d;
         address_q    <= address_d;
         write_data_q <= write_data_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         write_q      <= write_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         lane_q       <= lane_d;
         wdata_q      <= wdata_d;
      end
   end

   assign bus.ReqReady  = ready_q;
   assign bus.RspValid  = rsp_valid_q;
   assign bus.RspData   = rsp_data_q;
   assign bus.RspError  = rsp_error_q;
   assign bus.Address   = address_q;
   assign bus.WriteData = write_data_q;
   assign bus.MemRead   = mem_read_q;
   assign bus.MemWrite  = mem_write_q;
endmodule
